// File: rtl/midi_rx_pkg.sv
// -----------------------------------------------------------------------------
// midi_rx_pkg
//
// Shared definitions for the MIDI serial receiver:
//   MIDI_BAUD    - standard MIDI bit rate (31250 baud)
//   MIDI_RT_MIN  - first system real-time status byte (0xF8..0xFF)
//   rx_state_e   - receiver FSM state encoding
//   calc_div     - rounded clock divider for the oversample tick
// -----------------------------------------------------------------------------
package midi_rx_pkg;

    localparam int         MIDI_BAUD   = 31250;
    localparam logic [7:0] MIDI_RT_MIN = 8'hF8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } rx_state_e;

    // round(clk_hz / (baud * ovs)) using integer arithmetic.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        int den;
        den = baud * ovs;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/midi_rx_fifo.sv
// -----------------------------------------------------------------------------
// midi_rx_fifo
//
// Small show-ahead FIFO: data_o always shows the head entry and is meaningful
// while valid_o is high. A push and a pop in the same cycle on a full FIFO
// both take effect; a pop on an empty FIFO is ignored; a push on a full FIFO
// without a simultaneous pop is dropped (the caller reports the overflow).
//
// Parameters:
//   DEPTH  - number of entries (power of 2, >= 2)
//   W      - entry width in bits
//
// Ports:
//   clk_i    in   1   clock
//   rst_i    in   1   asynchronous active-high reset, empties the FIFO
//   push_i   in   1   write data_i this cycle
//   data_i   in   W   write data
//   pop_i    in   1   consume the head entry this cycle
//   data_o   out  W   head entry
//   valid_o  out  1   FIFO non-empty
//   full_o   out  1   FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module midi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic pop_ok;
    logic push_ok;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_FULL);
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && valid_o;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/midi_rx.sv
// -----------------------------------------------------------------------------
// midi_rx
//
// MIDI serial receiver (8N1, idle high). The pad input is brought in through a
// two-flop synchronizer, oversampled OVS times per bit by a tick generator,
// and each bit is decided by a 3-sample majority vote taken at mid-bit.
// Correctly framed bytes are queued in a show-ahead FIFO presented as a
// valid/ready stream.
//
// Handshake: a byte is transferred on every clock edge where rx_valid_o and
// rx_ready_i are both high; rx_data_o holds the head byte and is only
// meaningful while rx_valid_o is high; rx_valid_o does not depend on
// rx_ready_i.
//
// Optional build macro:
//   MIDI_RX_RT_FILT_EN - when defined, system real-time bytes 0xF8..0xFF are
//                        never queued (and never cause ovf_o). Framing checks
//                        are identical either way.
//
// Parameters:
//   CLK_HZ      core clock frequency in Hz
//   BAUD        serial bit rate
//   OVS         oversample ticks per bit (even, >= 8)
//   FIFO_DEPTH  byte FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk_i       in   1  core clock
//   rst_i       in   1  asynchronous active-high reset
//   midi_rx_i   in   1  asynchronous serial input, idle high
//   rx_data_o   out  8  FIFO head byte
//   rx_valid_o  out  1  FIFO non-empty
//   rx_ready_i  in   1  consumer pops the head when rx_valid_o & rx_ready_i
//   frm_err_o   out  1  one-cycle pulse on a bad stop bit
//   ovf_o       out  1  one-cycle pulse when a good byte is dropped (FIFO full)
//   busy_o      out  1  high while the receiver FSM is not idle
// -----------------------------------------------------------------------------
module midi_rx
    import midi_rx_pkg::*;
#(
    parameter int CLK_HZ     = 160_000_000,
    parameter int BAUD       = MIDI_BAUD,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       midi_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frm_err_o,
    output logic       ovf_o,
    output logic       busy_o
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TC_W  = $clog2(OVS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVS - 1);
    localparam logic [TC_W-1:0]  TC_MID   = TC_W'(OVS / 2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_e        state_q,    state_d;
    logic             sync1_q,    sync2_q;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [TC_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]       samp_q,     samp_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             frm_err_q,  frm_err_d;
    logic             ovf_q,      ovf_d;

    logic rx_s;
    logic tick;
    logic mid;
    logic vote;
    logic keep_byte;
    logic push_req;
    logic fifo_full;
    logic pop;

    assign rx_s = sync2_q;
    assign tick = (div_cnt_q == DIV_LAST);
    // Mid-bit decision point: the tick whose per-bit index is OVS/2.
    assign mid  = tick && (tick_cnt_q == TC_MID);

    // Majority of the two previous tick samples and the current one.
    assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

`ifdef MIDI_RX_RT_FILT_EN
    assign keep_byte = (shift_q < MIDI_RT_MIN);
`else
    assign keep_byte = 1'b1;
`endif

    assign pop = rx_valid_o && rx_ready_i;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frm_err_d  = 1'b0;
        push_req   = 1'b0;

        if (tick) begin
            samp_d     = {samp_q[1:0], rx_s};
            tick_cnt_d = (tick_cnt_q == TC_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    // Re-phase the tick so bit boundaries line up with the
                    // falling edge of the start bit.
                    state_d    = ST_START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (mid) begin
                    if (vote) begin
                        state_d = ST_IDLE;   // glitch shorter than half a bit
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shift_d   = {vote, shift_q[7:1]};   // LSB arrives first
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (mid) begin
                    if (vote) begin
                        // Leave half a bit early so the next start edge is
                        // never missed.
                        state_d  = ST_IDLE;
                        push_req = keep_byte;
                    end else begin
                        state_d   = ST_WAIT_HI;
                        frm_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_HI: begin
                // Breaks and held-low lines: wait for the line to recover.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ovf_d = push_req && fifo_full && !pop;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            samp_q     <= 3'b111;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= midi_rx_i;
            sync2_q    <= sync1_q;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign frm_err_o = frm_err_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    midi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .data_i  (shift_q),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .valid_o (rx_valid_o),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_midi_rx.sv
// -----------------------------------------------------------------------------
// tb_midi_rx
//
// Bench for midi_rx at a scaled-down clock (1 MHz, OVS = 8 -> 32 clocks per
// bit) so whole bytes take a few hundred cycles. Bytes expected on the output
// stream are queued when sent and compared as the consumer pops them.
// -----------------------------------------------------------------------------
module tb_midi_rx;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 31250;
  localparam int OVS     = 8;
  localparam int DEPTH   = 4;
  localparam int BIT_CYC = CLK_HZ / BAUD;   // 32
  localparam int CLK_NS  = 10;

  logic       clk;
  logic       rst;
  logic       midi;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frm_err;
  logic       ovf;
  logic       busy;

  midi_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVS        (OVS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .midi_rx_i  (midi),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .frm_err_o  (frm_err),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  initial begin
    #(200_000 * CLK_NS);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int         n_frm   = 0;
  int         n_ovf   = 0;
  int         n_unexp = 0;
  time        t_start = 0;
  int         last_lat = 0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (frm_err) n_frm++;
      if (ovf)     n_ovf++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_unexp++;
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", rx_data, exp_b);
          last_lat = int'(($time - t_start) / CLK_NS);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    midi = b;
    repeat (BIT_CYC - 1) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit, optional extra low time,
  // then one idle bit.
  task automatic send_byte(input logic [7:0] d, input logic stop_b, input int extra_low);
    @(negedge clk);
    midi = 1'b0;
    t_start = $time;
    repeat (BIT_CYC - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
    repeat (extra_low * BIT_CYC) @(negedge clk);
    drive_bit(1'b1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk);
    #1 rst = v;
  endtask

  // ---------------- test sequence ----------------
  int f0;
  int o0;

  initial begin
    rst      = 1'b1;
    midi     = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data",  rx_data,  0);
    check("rst_frm",   frm_err,  0);
    check("rst_ovf",   ovf,      0);
    check("rst_busy",  busy,     0);
    set_rst(1'b0);
    wait_cyc(2 * BIT_CYC);

    // Single byte with latency window (~9.5 bits + sync = ~311 clocks).
    f0 = n_frm; o0 = n_ovf;
    exp_q.push_back(8'h90);
    send_byte(8'h90, 1'b1, 0);
    wait_cyc(BIT_CYC);
    check("single_latency_in_window", (last_lat >= 300 && last_lat <= 320), 1);
    check("single_frm", n_frm - f0, 0);
    check("single_ovf", n_ovf - o0, 0);

    // Glitch shorter than half a bit.
    f0 = n_frm; o0 = n_ovf;
    @(negedge clk);
    midi = 1'b0;
    wait_cyc(5);
    midi = 1'b1;
    wait_cyc(BIT_CYC);
    check("glitch_busy",  busy,       0);
    check("glitch_valid", rx_valid,   0);
    check("glitch_frm",   n_frm - f0, 0);
    check("glitch_ovf",   n_ovf - o0, 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 0);
    wait_cyc(BIT_CYC);

    // Framing error: stop bit low, line low two more bit times.
    f0 = n_frm; o0 = n_ovf;
    send_byte(8'h55, 1'b0, 2);
    check("frame_frm",  n_frm - f0, 1);
    check("frame_ovf",  n_ovf - o0, 0);
    check("frame_busy", busy,       0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 0);
    wait_cyc(BIT_CYC);

    // Overflow: consumer stalled, five bytes sent, fifth dropped.
    f0 = n_frm; o0 = n_ovf;
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 0);
    end
    check("ovf_pulses", n_ovf - o0, 1);
    check("ovf_frm",    n_frm - f0, 0);
    check("ovf_valid",  rx_valid,   1);
    check("ovf_head",   rx_data,    8'h01);
    set_ready(1'b1);
    wait_cyc(10);
    check("ovf_drained_valid", rx_valid,      0);
    check("ovf_drained_queue", exp_q.size(),  0);

    // Reset mid-byte with a stale entry in the FIFO.
    set_ready(1'b0);
    send_byte(8'h33, 1'b1, 0);
    check("pre_rst_valid", rx_valid, 1);
    @(negedge clk);
    midi = 1'b0;
    repeat (BIT_CYC - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    @(negedge clk);
    midi = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clk);
    check("mid_busy", busy, 1);
    set_rst(1'b1);
    @(negedge clk);
    check("mrst_valid", rx_valid, 0);
    check("mrst_data",  rx_data,  0);
    check("mrst_busy",  busy,     0);
    check("mrst_frm",   frm_err,  0);
    check("mrst_ovf",   ovf,      0);
    wait_cyc(BIT_CYC);
    set_rst(1'b0);
    set_ready(1'b1);
    wait_cyc(2 * BIT_CYC);
    check("post_rst_valid", rx_valid, 0);
    f0 = n_frm; o0 = n_ovf;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, 0);
    wait_cyc(BIT_CYC);
    check("post_rst_frm", n_frm - f0, 0);

    // Real-time bytes.
    o0 = n_ovf;
`ifdef MIDI_RX_RT_FILT_EN
    exp_q.push_back(8'h90);
`else
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'hFE);
`endif
    send_byte(8'hF8, 1'b1, 0);
    send_byte(8'h90, 1'b1, 0);
    send_byte(8'hFE, 1'b1, 0);
    wait_cyc(BIT_CYC);
    check("rt_ovf",   n_ovf - o0,   0);
    check("rt_queue", exp_q.size(), 0);

    // Final scoreboard state.
    check("unexpected_pops", n_unexp,      0);
    check("final_queue",     exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
